// File: rtl/interrupt_ctrl_pkg.sv
// Shared definitions for the external-interrupt responder:
// FSM encodings, line-count limits and a one-hot decode helper.
package interrupt_ctrl_pkg;

  localparam int NUM_IRQ_MAX = 8;
  localparam int IRQ_NO_W    = 3;

  typedef enum logic [1:0] {
    INT_IDLE    = 2'd0,
    INT_REQ     = 2'd1,
    INT_SERVICE = 2'd2
  } int_state_e;

  // One-hot select of a line index across the maximum line count.
  function automatic logic [NUM_IRQ_MAX-1:0] irq_onehot(input logic [IRQ_NO_W-1:0] idx);
    logic [NUM_IRQ_MAX-1:0] oh;
    oh = {NUM_IRQ_MAX{1'b0}};
    for (int i = 0; i < NUM_IRQ_MAX; i++) begin
      oh[i] = (idx == IRQ_NO_W'(i)) ? 1'b1 : 1'b0;
    end
    return oh;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line capture: two-flop synchronizer for an asynchronous interrupt
// line followed by a previous-value flop for rising-edge detection.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronizer chain and edge-history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= irq;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/interrupt_ctrl.sv
// External-interrupt responder: pending capture, mask, fixed lowest-index
// priority and a request/service handshake with the pipeline.
module interrupt_ctrl #(
  parameter int NUM_IRQ  = 8,
  parameter int IRQ_NO_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                status,
  input  logic                int_ack,
  output logic                interrupter,
  output logic                valid_interrupter,
  output logic [IRQ_NO_W-1:0] interrupter_no,
  output logic [NUM_IRQ-1:0]  pending
);

  import interrupt_ctrl_pkg::*;

  int_state_e                state_r;
  int_state_e                state_next_s;
  logic [NUM_IRQ-1:0]        rise_s;
  logic [NUM_IRQ-1:0]        pending_r;
  logic [NUM_IRQ-1:0]        pending_next_s;
  logic [NUM_IRQ-1:0]        eligible_s;
  logic [NUM_IRQ-1:0]        clear_s;
  logic [NUM_IRQ_MAX-1:0]    ack_onehot_s;
  logic [IRQ_NO_W-1:0]       winner_s;
  logic [IRQ_NO_W-1:0]       irq_no_r;
  logic [IRQ_NO_W-1:0]       irq_no_next_s;
  logic                      seen_status_r;
  logic                      seen_status_next_s;
  logic                      interrupter_r;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq_in[g]),
      .rise (rise_s[g])
    );
  end

  assign eligible_s   = pending_r & irq_mask;
  assign ack_onehot_s = irq_onehot(irq_no_r);

  // Fixed priority: scan downwards so the lowest eligible index is left last.
  always_comb begin
    winner_s = {IRQ_NO_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      winner_s = eligible_s[i] ? IRQ_NO_W'(i) : winner_s;
    end
  end

  // Request/service sequencing; a committed request ignores mask and status.
  always_comb begin
    state_next_s       = state_r;
    irq_no_next_s      = irq_no_r;
    seen_status_next_s = seen_status_r;
    clear_s            = {NUM_IRQ{1'b0}};
    case (state_r)
      INT_IDLE: begin
        if ((|eligible_s) && !status) begin
          irq_no_next_s = winner_s;
          state_next_s  = INT_REQ;
        end else begin
          state_next_s  = INT_IDLE;
        end
      end
      INT_REQ: begin
        if (int_ack) begin
          clear_s      = ack_onehot_s[NUM_IRQ-1:0];
          state_next_s = INT_SERVICE;
        end else begin
          state_next_s = INT_REQ;
        end
      end
      INT_SERVICE: begin
        // Leave only once the handler has been seen running and ERET dropped status.
        if (seen_status_r && !status) begin
          seen_status_next_s = 1'b0;
          state_next_s       = INT_IDLE;
        end else if (status) begin
          seen_status_next_s = 1'b1;
          state_next_s       = INT_SERVICE;
        end else begin
          seen_status_next_s = seen_status_r;
          state_next_s       = INT_SERVICE;
        end
      end
      default: begin
        seen_status_next_s = 1'b0;
        state_next_s       = INT_IDLE;
      end
    endcase
  end

  // A fresh edge arriving in the ack cycle keeps its pending bit.
  assign pending_next_s = (pending_r & ~clear_s) | rise_s;

  // State, pending and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= INT_IDLE;
      pending_r     <= {NUM_IRQ{1'b0}};
      irq_no_r      <= {IRQ_NO_W{1'b0}};
      seen_status_r <= 1'b0;
      interrupter_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      pending_r     <= pending_next_s;
      irq_no_r      <= irq_no_next_s;
      seen_status_r <= seen_status_next_s;
      interrupter_r <= (state_next_s == INT_REQ) ? 1'b1 : 1'b0;
    end
  end

  assign interrupter       = interrupter_r;
  assign interrupter_no    = irq_no_r;
  assign pending           = pending_r;
  assign valid_interrupter = |eligible_s;

endmodule
